// File: rtl/hex_display_scan_pkg.sv
// Shared constants and helpers for the multiplexed hex display scanner.
package hex_display_scan_pkg;

  localparam int unsigned NUM_DIGITS          = 4;
  localparam int unsigned NIB_W               = 4;
  localparam int unsigned VALUE_W             = NUM_DIGITS * NIB_W;
  localparam int unsigned IDX_W               = 2;
  localparam int unsigned REFRESH_DIV_DEFAULT = 50000;

  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = 4'b1111;

  typedef logic [NIB_W-1:0]      nibble_t;
  typedef logic [VALUE_W-1:0]    value_t;
  typedef logic [IDX_W-1:0]      idx_t;
  typedef logic [NUM_DIGITS-1:0] anode_t;

  // Nibble shown in slot idx.
  function automatic nibble_t sel_nibble(input value_t v, input idx_t idx);
    nibble_t n;
    case (idx)
      2'd0:    n = v[3:0];
      2'd1:    n = v[7:4];
      2'd2:    n = v[11:8];
      default: n = v[15:12];
    endcase
    return n;
  endfunction

  // Active-low anode pattern for slot idx, with optional leading-zero blanking.
  function automatic anode_t anode_pattern(input value_t v, input idx_t idx,
                                           input logic blank_lz);
    logic   blank;
    anode_t one_hot;
    case (idx)
      2'd0:    blank = 1'b0;
      2'd1:    blank = (v[15:4] == 12'h000);
      2'd2:    blank = (v[15:8] == 8'h00);
      default: blank = (v[15:12] == 4'h0);
    endcase
    one_hot = 4'b0001 << idx;
    return (blank && blank_lz) ? ANODE_OFF : ~one_hot;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler; tick_o is high for the last cycle of each DIV-cycle period.
module tick_gen #(
  parameter int unsigned DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  output logic tick_o
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // tick is registered by looking one count ahead.
  always_comb begin
    cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    tick_d = (cnt_d == LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/hex_display_scan.sv
// Four-digit time-multiplexed hex display scanner with frame-synchronous value commit.
module hex_display_scan
  import hex_display_scan_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = REFRESH_DIV_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] value,
  input  logic        blank_lz,
  output logic [3:0]  digit,
  output logic [3:0]  an,
  output logic        frame_done
);

  logic    tick;
  logic    frame_end;
  idx_t    idx_q, idx_d;
  value_t  committed_q, committed_d;
  value_t  pending_q, pending_d;
  logic    pend_flag_q, pend_flag_d;
  nibble_t digit_q, digit_d;
  anode_t  an_q, an_d;
  logic    frame_done_q, frame_done_d;

  tick_gen #(.DIV(REFRESH_DIV)) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .tick_o (tick)
  );

  assign frame_end = tick && (idx_q == idx_t'(NUM_DIGITS - 1));

  // Loads are staged in pending and only committed at a frame boundary, so a frame never tears.
  always_comb begin
    idx_d        = idx_q;
    committed_d  = committed_q;
    pending_d    = pending_q;
    pend_flag_d  = pend_flag_q;
    digit_d      = digit_q;
    an_d         = an_q;
    frame_done_d = frame_end;

    if (tick) begin
      idx_d = idx_q + idx_t'(1);
    end

    if (frame_end) begin
      pend_flag_d = 1'b0;
      if (load) begin
        committed_d = value;
      end else if (pend_flag_q) begin
        committed_d = pending_q;
      end
    end else if (load) begin
      pending_d   = value;
      pend_flag_d = 1'b1;
    end

    if (tick) begin
      digit_d = sel_nibble(committed_d, idx_d);
      an_d    = anode_pattern(committed_d, idx_d, blank_lz);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q        <= '0;
      committed_q  <= '0;
      pending_q    <= '0;
      pend_flag_q  <= 1'b0;
      digit_q      <= '0;
      an_q         <= 4'b1110;
      frame_done_q <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      committed_q  <= committed_d;
      pending_q    <= pending_d;
      pend_flag_q  <= pend_flag_d;
      digit_q      <= digit_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign digit      = digit_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_hex_display_scan.sv
// Directed bench for hex_display_scan with a 4-cycle refresh divider.
module tb_hex_display_scan;

  logic        clk;
  logic        rst;
  logic        load;
  logic [15:0] value;
  logic        blank_lz;
  logic [3:0]  digit;
  logic [3:0]  an;
  logic        frame_done;

  int total;
  int bad;
  int ecnt;

  hex_display_scan #(.REFRESH_DIV(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .value      (value),
    .blank_lz   (blank_lz),
    .digit      (digit),
    .an         (an),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance until ecnt rising edges have passed since the last reset release.
  task automatic go(input int e);
    while (ecnt < e) begin
      @(posedge clk);
      #1;
      ecnt++;
    end
  endtask

  task automatic do_load(input logic [15:0] v);
    value = v;
    load  = 1'b1;
    go(ecnt + 1);
    load  = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [3:0] exp_dig,
                     input logic [3:0] exp_an, input logic exp_fd);
    total++;
    assert (digit === exp_dig) else begin
      bad++;
      $error("FAIL %s digit: got %h expected %h", tag, digit, exp_dig);
    end
    total++;
    assert (an === exp_an) else begin
      bad++;
      $error("FAIL %s an: got %b expected %b", tag, an, exp_an);
    end
    total++;
    assert (frame_done === exp_fd) else begin
      bad++;
      $error("FAIL %s frame_done: got %b expected %b", tag, frame_done, exp_fd);
    end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    ecnt     = 0;
    rst      = 1'b1;
    load     = 1'b0;
    value    = 16'h0000;
    blank_lz = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset", 4'h0, 4'b1110, 1'b0);
    rst  = 1'b0;
    ecnt = 0;

    // Free scan with zero value, no blanking.
    for (int e = 1; e <= 20; e++) begin
      go(e);
      chk($sformatf("scan_e%0d", e), 4'h0, ~(4'b0001 << ((e / 4) % 4)), (e % 16 == 0));
    end

    // Load during slot 1; shown only from the next frame.
    do_load(16'h1A3F);
    go(31);  chk("1a3f_hold", 4'h0, 4'b0111, 1'b0);
    go(32);  chk("1a3f_s0",   4'hF, 4'b1110, 1'b1);
    go(36);  chk("1a3f_s1",   4'h3, 4'b1101, 1'b0);
    go(40);  chk("1a3f_s2",   4'hA, 4'b1011, 1'b0);
    go(44);  chk("1a3f_s3",   4'h1, 4'b0111, 1'b0);
    go(48);  chk("1a3f_rep",  4'hF, 4'b1110, 1'b1);

    // Leading-zero blanking.
    blank_lz = 1'b1;
    do_load(16'h0050);
    go(63);  chk("0050_hold", 4'h1, 4'b0111, 1'b0);
    go(64);  chk("0050_s0",   4'h0, 4'b1110, 1'b1);
    go(68);  chk("0050_s1",   4'h5, 4'b1101, 1'b0);
    go(72);  chk("0050_s2",   4'h0, 4'b1111, 1'b0);
    go(76);  chk("0050_s3",   4'h0, 4'b1111, 1'b0);
    do_load(16'h0000);
    go(80);  chk("0000_s0",   4'h0, 4'b1110, 1'b1);
    go(84);  chk("0000_s1",   4'h0, 4'b1111, 1'b0);
    go(88);  chk("0000_s2",   4'h0, 4'b1111, 1'b0);
    go(92);  chk("0000_s3",   4'h0, 4'b1111, 1'b0);

    // Load on the frame-boundary cycle overrides an older pending value.
    blank_lz = 1'b0;
    do_load(16'h1111);
    go(95);
    do_load(16'hBEEF);
    chk("beef_s0",  4'hF, 4'b1110, 1'b1);
    go(100); chk("beef_s1",  4'hE, 4'b1101, 1'b0);
    go(104); chk("beef_s2",  4'hE, 4'b1011, 1'b0);
    go(108); chk("beef_s3",  4'hB, 4'b0111, 1'b0);
    go(112); chk("beef_rep", 4'hF, 4'b1110, 1'b1);

    // Two loads in one frame: last wins.
    do_load(16'h1234);
    go(117);
    do_load(16'h5678);
    go(127); chk("5678_hold", 4'hB, 4'b0111, 1'b0);
    go(128); chk("5678_s0",   4'h8, 4'b1110, 1'b1);
    go(132); chk("5678_s1",   4'h7, 4'b1101, 1'b0);
    go(136); chk("5678_s2",   4'h6, 4'b1011, 1'b0);
    go(140); chk("5678_s3",   4'h5, 4'b0111, 1'b0);

    // Asynchronous reset mid-slot 2 with a load pending.
    do_load(16'h1234);
    go(144); chk("1234_s0", 4'h4, 4'b1110, 1'b1);
    go(152); chk("1234_s2", 4'h2, 4'b1011, 1'b0);
    do_load(16'hABCD);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst", 4'h0, 4'b1110, 1'b0);
    @(posedge clk);
    #1;
    rst  = 1'b0;
    ecnt = 0;
    go(1);  chk("post_e1",  4'h0, 4'b1110, 1'b0);
    go(4);  chk("post_e4",  4'h0, 4'b1101, 1'b0);
    go(15); chk("post_e15", 4'h0, 4'b0111, 1'b0);
    go(16); chk("post_e16", 4'h0, 4'b1110, 1'b1);
    go(17); chk("post_e17", 4'h0, 4'b1110, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
